freq_gen_bcd: RTL

//   Programmable square-wave generator; the source-side counterpart of the 8-digit BCD frequency meter.

---
 rtl/freq_gen_pkg.sv | 27 ++
 rtl/freq_gen_bcd_seq_divider.sv | 78 +++++++
 rtl/freq_gen_bcd.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the BCD-programmed square-wave generator.
// The optional FREQ_GEN_PULSE_EN build only affects freq_gen_bcd, not this package.
package freq_gen_pkg;

  // Control FSM states, exposed on the debug struct of freq_gen_bcd.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_DIV    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // Observation bundle: FSM state plus whether the last commit divided exactly.
  typedef struct packed {
    state_t state;
    logic   div_exact;
  } dbg_t;

  localparam int BCD_DIGITS = 8;
  localparam int DIGIT_W    = 4;

  // A BCD nibble is legal only in the range 0..9.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/freq_gen_bcd_seq_divider.sv
// W-bit restoring divider, one quotient bit per clock.
// Handshake: start is a one-cycle request, taken only while the divider is idle;
// last is high during the final iteration; done pulses for one cycle when quotient
// and remainder first hold the result, and they stay valid until the next start.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         last,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  div_q;
  logic [CW-1:0] step_cnt;
  logic          run_q;
  logic          done_q;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          fits;

  // One restoring step: bring in the next dividend bit and try to subtract.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, div_q};
    fits    = (shifted >= {1'b0, div_q});
  end

  // Iteration registers; the dividend shifts out of quo_q as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      step_cnt <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !run_q) begin
        rem_q    <= '0;
        quo_q    <= dividend;
        div_q    <= divisor;
        step_cnt <= CW'(W);
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (fits) begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        step_cnt <= step_cnt - 1'b1;
        if (step_cnt == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign last      = run_q && (step_cnt == CW'(1));
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/freq_gen_bcd.sv
// Programmable square-wave generator driven by an 8-digit packed BCD frequency.
// The BCD value is converted to binary one digit per cycle, NUM = CLK_HZ/2 is divided
// by it to get the half period, and FOUT toggles every half period.
// Build option FREQ_GEN_PULSE_EN adds output FPULSE, a one-cycle pulse when FOUT rises.
module freq_gen_bcd
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int W      = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [31:0] DATIN,
  output logic        FOUT,
  output logic        ACTIVE,
  output logic        BUSY,
  output logic        ERR,
  output logic        OVR,
`ifdef FREQ_GEN_PULSE_EN
  output logic        FPULSE,
`endif
  output dbg_t        dbg
);

  localparam logic [W-1:0] NUM = W'(CLK_HZ / 2);

  state_t       state_q, state_d;

  // BCD conversion
  logic [31:0]  datin_sh;
  logic [2:0]   digit_idx;
  logic [W-1:0] bin_q;
  logic [W-1:0] bin_next;
  logic [3:0]   digit;
  logic         load_acc;

  // Divider interface
  logic         div_start;
  logic         div_last;
  logic         div_done;
  logic [W-1:0] div_quo;
  logic [W-1:0] div_rem;

  // Commit decode
  logic         commit_zero;
  logic         commit_run;
  logic [W-1:0] half_new;

  // Status
  logic         err_q;
  logic         ovr_q;
  logic         exact_q;

  // Generator
  logic         active_q;
  logic         fout_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] half_q;
  logic [W-1:0] pend_half;
  logic         pend_v;
  logic         toggle;

  assign digit    = datin_sh[31:28];
  assign bin_next = (bin_q << 3) + (bin_q << 1) + W'(digit);
  assign load_acc = (state_q == S_IDLE) && LOAD;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the divider is started on the last conversion cycle so S_DIV
  // lasts exactly W cycles.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD) state_d = S_CONV;
      end
      S_CONV: begin
        if (!digit_valid(digit)) begin
          state_d = S_IDLE;
        end else if (digit_idx == 3'(BCD_DIGITS - 1)) begin
          if (bin_next == '0) begin
            state_d = S_COMMIT;
          end else begin
            state_d   = S_DIV;
            div_start = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (div_last) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // BCD-to-binary conversion, most significant digit first; a bad digit aborts.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      datin_sh  <= '0;
      digit_idx <= '0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else if (load_acc) begin
      datin_sh  <= DATIN;
      digit_idx <= '0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else if (state_q == S_CONV) begin
      if (!digit_valid(digit)) begin
        err_q <= 1'b1;
      end else begin
        bin_q     <= bin_next;
        datin_sh  <= {datin_sh[27:0], 4'h0};
        digit_idx <= digit_idx + 3'd1;
      end
    end
  end

  seq_divider #(
    .W (W)
  ) u_div (
    .clk       (CLK),
    .rst_n     (RST_N),
    .start     (div_start),
    .dividend  (NUM),
    .divisor   (bin_next),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Commit decode: a zero quotient means f > NUM, so the half period clamps to 1.
  always_comb begin
    commit_zero = (state_q == S_COMMIT) && (bin_q == '0);
    commit_run  = (state_q == S_COMMIT) && (bin_q != '0) && div_done;
    half_new    = (div_quo == '0) ? W'(1) : div_quo;
  end

  // Sticky status flags, cleared by each accepted load.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovr_q   <= 1'b0;
      exact_q <= 1'b0;
    end else if (load_acc) begin
      ovr_q   <= 1'b0;
      exact_q <= 1'b0;
    end else if (commit_run) begin
      ovr_q   <= (div_quo == '0);
      exact_q <= (div_rem == '0);
    end
  end

  assign toggle = active_q && (cnt_q == half_q - W'(1));

  // Half-period counter; while running, a new half period waits for the next toggle
  // so no phase is ever cut short. A toggle in the commit cycle uses the old setting.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      active_q  <= 1'b0;
      fout_q    <= 1'b0;
      cnt_q     <= '0;
      half_q    <= '0;
      pend_half <= '0;
      pend_v    <= 1'b0;
    end else if (commit_zero) begin
      active_q <= 1'b0;
      fout_q   <= 1'b0;
      cnt_q    <= '0;
      pend_v   <= 1'b0;
    end else if (commit_run && !active_q) begin
      half_q   <= half_new;
      cnt_q    <= '0;
      fout_q   <= 1'b0;
      active_q <= 1'b1;
      pend_v   <= 1'b0;
    end else if (active_q) begin
      if (toggle) begin
        cnt_q  <= '0;
        fout_q <= ~fout_q;
        if (pend_v) begin
          half_q <= pend_half;
          pend_v <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
      if (commit_run) begin
        pend_half <= half_new;
        pend_v    <= 1'b1;
      end
    end
  end

`ifdef FREQ_GEN_PULSE_EN
  logic fpulse_q;

  // Rising-edge strobe, registered alongside FOUT so both change on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) fpulse_q <= 1'b0;
    else        fpulse_q <= toggle && !commit_zero && !fout_q;
  end

  assign FPULSE = fpulse_q;
`endif

  assign FOUT          = fout_q;
  assign ACTIVE        = active_q;
  assign BUSY          = (state_q != S_IDLE);
  assign ERR           = err_q;
  assign OVR           = ovr_q;
  assign dbg.state     = state_q;
  assign dbg.div_exact = exact_q;

endmodule
